// File: rtl/game_sequencer_if.sv
// Pulse/status bundle between key_control, tick_timer, snake_field and game_sequencer.
// Optional hiscore signal is present when SNAKE_HISCORE_EN is defined.
interface game_sequencer_if #(
   parameter int unsigned SCORE_W = 10
);
   logic               start;
   logic               pause;
   logic               tick;
   logic               collision;
   logic               food_eaten;
   logic               field_start;
   logic               step;
   logic [1:0]         state;
   logic [SCORE_W-1:0] score;
   logic [2:0]         level;
`ifdef SNAKE_HISCORE_EN
   logic [SCORE_W-1:0] hiscore;
`endif

   // Master drives the event pulses; slave is the sequencer.
   modport master (
      output start, pause, tick, collision, food_eaten,
`ifdef SNAKE_HISCORE_EN
      input  hiscore,
`endif
      input  field_start, step, state, score, level
   );

   modport slave (
      input  start, pause, tick, collision, food_eaten,
`ifdef SNAKE_HISCORE_EN
      output hiscore,
`endif
      output field_start, step, state, score, level
   );
endinterface

// File: rtl/game_sequencer.sv
// Snake game-level controller: run/pause/over FSM, tick-to-step divider, score and level.
// Define SNAKE_HISCORE_EN to add a hiscore register that survives restarts.
module game_sequencer #(
   parameter int unsigned BASE_PERIOD    = 8,
   parameter int unsigned MAX_LEVEL      = 6,
   parameter int unsigned FOOD_PER_LEVEL = 4,
   parameter int unsigned SCORE_W        = 10
) (
   input logic             clk,
   input logic             rst,
   game_sequencer_if.slave bus
);
   localparam int unsigned TickW = $clog2(BASE_PERIOD + 1);
   localparam int unsigned FoodW = $clog2(FOOD_PER_LEVEL + 1);

   typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPause = 2'd2, StOver = 2'd3} state_e;

   state_e             state_q, state_d;
   logic               field_start_q, field_start_d;
   logic               step_q, step_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         level_q, level_d;
   logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [FoodW-1:0]   food_cnt_q, food_cnt_d;
   logic [TickW-1:0]   period_m1;
   logic               run_active;
`ifdef SNAKE_HISCORE_EN
   logic [SCORE_W-1:0] hiscore_q, hiscore_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         field_start_q <= 1'b0;
         step_q        <= 1'b0;
         score_q       <= '0;
         level_q       <= '0;
         tick_cnt_q    <= '0;
         food_cnt_q    <= '0;
`ifdef SNAKE_HISCORE_EN
         hiscore_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         field_start_q <= field_start_d;
         step_q        <= step_d;
         score_q       <= score_d;
         level_q       <= level_d;
         tick_cnt_q    <= tick_cnt_d;
         food_cnt_q    <= food_cnt_d;
`ifdef SNAKE_HISCORE_EN
         hiscore_q     <= hiscore_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = StRun;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StRun: begin
               if (bus.collision)  state_d = StOver;
               else if (bus.pause) state_d = StPause;
            end
            StPause: if (bus.pause) state_d = StRun;
            StOver:  state_d = StOver;
            default: state_d = StIdle;
         endcase
      end
   end

   // Counting only happens in RUN on a cycle not claimed by a higher-priority event.
   assign run_active = (state_q == StRun) && !bus.start && !bus.collision && !bus.pause;
   assign period_m1  = TickW'(BASE_PERIOD - 1) - TickW'(level_q);

   always_comb begin
      field_start_d = bus.start;
      step_d        = 1'b0;
      score_d       = score_q;
      level_d       = level_q;
      tick_cnt_d    = tick_cnt_q;
      food_cnt_d    = food_cnt_q;
`ifdef SNAKE_HISCORE_EN
      hiscore_d     = hiscore_q;
`endif
      if (bus.start) begin
         score_d    = '0;
         level_d    = '0;
         tick_cnt_d = '0;
         food_cnt_d = '0;
      end else if (run_active) begin
         if (bus.tick) begin
            // >= guards a count left above the shortened period after a level-up.
            if (tick_cnt_q >= period_m1) begin
               step_d     = 1'b1;
               tick_cnt_d = '0;
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
         end
         if (bus.food_eaten) begin
            if (score_q != '1) score_d = score_q + 1'b1;
            if (food_cnt_q == FoodW'(FOOD_PER_LEVEL - 1)) begin
               food_cnt_d = '0;
               if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 1'b1;
            end else begin
               food_cnt_d = food_cnt_q + 1'b1;
            end
         end
      end
`ifdef SNAKE_HISCORE_EN
      if (!bus.start && (state_q == StRun) && bus.collision && (score_q > hiscore_q)) begin
         hiscore_d = score_q;
      end
`endif
   end

   assign bus.field_start = field_start_q;
   assign bus.step        = step_q;
   assign bus.state       = state_q;
   assign bus.score       = score_q;
   assign bus.level       = level_q;
`ifdef SNAKE_HISCORE_EN
   assign bus.hiscore     = hiscore_q;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer; expected values are hand-computed.
module tb_game_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   steps;

   always #5 clk = ~clk;

   game_sequencer_if #(.SCORE_W(10)) bus ();

   game_sequencer #(
      .BASE_PERIOD    (8),
      .MAX_LEVEL      (6),
      .FOOD_PER_LEVEL (4),
      .SCORE_W        (10)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of pulses, then sample registered outputs 1ns after the edge.
   task automatic apply(input logic s, input logic p, input logic t, input logic c,
                        input logic f);
      bus.start = s; bus.pause = p; bus.tick = t; bus.collision = c; bus.food_eaten = f;
      @(posedge clk); #1;
      bus.start = 0; bus.pause = 0; bus.tick = 0; bus.collision = 0; bus.food_eaten = 0;
   endtask

   task automatic ticks(input int n, output int nsteps);
      nsteps = 0;
      for (int i = 0; i < n; i++) begin
         apply(0, 0, 1, 0, 0);
         nsteps += int'(bus.step);
      end
   endtask

   initial begin
      bus.start = 0; bus.pause = 0; bus.tick = 0; bus.collision = 0; bus.food_eaten = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      check_eq("rst_state", 32'(bus.state), 0);
      check_eq("rst_score", 32'(bus.score), 0);
      check_eq("rst_level", 32'(bus.level), 0);
      check_eq("rst_step", 32'(bus.step), 0);
      check_eq("rst_fstart", 32'(bus.field_start), 0);

      // IDLE ignores events
      apply(0, 1, 1, 1, 1);
      check_eq("idle_state", 32'(bus.state), 0);
      check_eq("idle_score", 32'(bus.score), 0);

      // 1: start then 16 ticks, steps after tick 8 and 16
      apply(1, 0, 0, 0, 0);
      check_eq("t1_fstart", 32'(bus.field_start), 1);
      check_eq("t1_state", 32'(bus.state), 1);
      apply(0, 0, 0, 0, 0);
      check_eq("t1_fstart_drop", 32'(bus.field_start), 0);
      for (int i = 1; i <= 16; i++) begin
         apply(0, 0, 1, 0, 0);
         check_eq($sformatf("t1_step%0d", i), 32'(bus.step), 32'((i == 8) || (i == 16)));
      end
      apply(0, 0, 0, 0, 0);
      check_eq("t1_step_drop", 32'(bus.step), 0);

      // 2: four food -> level 1, period 7
      for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1);
      check_eq("t2_score4", 32'(bus.score), 4);
      check_eq("t2_level1", 32'(bus.level), 1);
      for (int i = 1; i <= 14; i++) begin
         apply(0, 0, 1, 0, 0);
         check_eq($sformatf("t2_step%0d", i), 32'(bus.step), 32'((i == 7) || (i == 14)));
      end
      for (int i = 0; i < 28; i++) apply(0, 0, 0, 0, 1);
      check_eq("t2_score32", 32'(bus.score), 32);
      check_eq("t2_level_sat", 32'(bus.level), 6);
      ticks(4, steps);
      check_eq("t2_period2_steps", 32'(steps), 2);

      // 3: pause holds tick_cnt
      apply(0, 0, 1, 0, 0);
      check_eq("t3_pre_step", 32'(bus.step), 0);
      apply(0, 1, 0, 0, 0);
      check_eq("t3_paused", 32'(bus.state), 2);
      ticks(20, steps);
      check_eq("t3_no_step_paused", 32'(steps), 0);
      apply(0, 0, 0, 0, 1);
      check_eq("t3_food_ignored", 32'(bus.score), 32);
      apply(0, 1, 0, 0, 0);
      check_eq("t3_resumed", 32'(bus.state), 1);
      apply(0, 0, 1, 0, 0);
      check_eq("t3_resume_step", 32'(bus.step), 1);

      // 4: collision with food and qualifying tick
      apply(0, 0, 1, 0, 0);
      check_eq("t4_pre_step", 32'(bus.step), 0);
      apply(0, 0, 1, 1, 1);
      check_eq("t4_over", 32'(bus.state), 3);
      check_eq("t4_score_held", 32'(bus.score), 32);
      check_eq("t4_no_step", 32'(bus.step), 0);
      apply(0, 1, 0, 0, 0);
      ticks(10, steps);
      check_eq("t4_over_steps", 32'(steps), 0);
      check_eq("t4_over_state", 32'(bus.state), 3);
      check_eq("t4_over_level", 32'(bus.level), 6);

      // 5: restart from OVER
      apply(1, 0, 0, 0, 0);
      check_eq("t5_fstart", 32'(bus.field_start), 1);
      check_eq("t5_score", 32'(bus.score), 0);
      check_eq("t5_level", 32'(bus.level), 0);
      check_eq("t5_state", 32'(bus.state), 1);
`ifdef SNAKE_HISCORE_EN
      check_eq("t5_hiscore", 32'(bus.hiscore), 32);
`endif

      // 6: start+pause while paused, then rst in RUN on a qualifying tick
      apply(0, 1, 0, 0, 0);
      check_eq("t6_paused", 32'(bus.state), 2);
      apply(1, 1, 0, 0, 0);
      check_eq("t6_restart_state", 32'(bus.state), 1);
      check_eq("t6_restart_fstart", 32'(bus.field_start), 1);
      ticks(7, steps);
      check_eq("t6_pre_steps", 32'(steps), 0);
      rst = 1;
      apply(0, 0, 1, 0, 0);
      rst = 0;
      check_eq("t6_rst_state", 32'(bus.state), 0);
      check_eq("t6_rst_step", 32'(bus.step), 0);
      check_eq("t6_rst_fstart", 32'(bus.field_start), 0);
`ifdef SNAKE_HISCORE_EN
      check_eq("t6_rst_hiscore", 32'(bus.hiscore), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
